sd_block_arbiter: RTL and testbench

- Shares the single SD card controller between NREQ block-transfer requesters using round-robin arbitration.
- Latches the granted requester's address and direction, issues the read or write command to the controller, and counts data bytes/words to the block size.
- Steers read bytes and write-word strobes to the owner, and signals DONE or ERR (timeout) per requester.
- Sits between the system-side DMA/requesters and the SD controller's CTRL_READ/CTRL_WRITE/ADDRESS/WRITEBUFFER/READBUFFER interface.

---
 rtl/sd_block_arbiter_if.sv | 39 +++
 rtl/sd_block_arbiter.sv | 144 ++++++++++++++
 tb/tb_sd_block_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_block_arbiter_if.sv
// Bus bundle between the block arbiter, its requesters and the SD controller.
interface sd_block_arbiter_if #(
   parameter int NREQ = 2
);
   logic [NREQ-1:0]      REQ;
   logic [NREQ-1:0]      REQ_WRITE;
   logic [32*NREQ-1:0]   REQ_ADDR;
   logic [32*NREQ-1:0]   REQ_WDATA;
   logic [NREQ-1:0]      GNT;
   logic [7:0]           RDATA;
   logic [NREQ-1:0]      RVALID;
   logic [NREQ-1:0]      WTAKE;
   logic [NREQ-1:0]      DONE;
   logic [NREQ-1:0]      ERR;
   logic                 SD_READY;
   logic                 SD_BYTE_READY;
   logic [7:0]           SD_RDATA;
   logic                 SD_WTAKE;
   logic                 SD_READ;
   logic                 SD_WRITE;
   logic [31:0]          SD_ADDR;
   logic [31:0]          SD_WDATA;

   // arbiter side
   modport slave (
      input  REQ, REQ_WRITE, REQ_ADDR, REQ_WDATA,
      input  SD_READY, SD_BYTE_READY, SD_RDATA, SD_WTAKE,
      output GNT, RDATA, RVALID, WTAKE, DONE, ERR,
      output SD_READ, SD_WRITE, SD_ADDR, SD_WDATA
   );

   // requesters plus SD controller side
   modport master (
      output REQ, REQ_WRITE, REQ_ADDR, REQ_WDATA,
      output SD_READY, SD_BYTE_READY, SD_RDATA, SD_WTAKE,
      input  GNT, RDATA, RVALID, WTAKE, DONE, ERR,
      input  SD_READ, SD_WRITE, SD_ADDR, SD_WDATA
   );
endinterface

// File: rtl/sd_block_arbiter.sv
// Round-robin arbiter sharing one SD controller between NREQ block requesters.
//
// state | meaning
// IDLE  | no owner; grant when controller ready and any REQ set
// ISSUE | CTRL_READ/CTRL_WRITE held until controller drops READY
// XFER  | counting bytes (read) or words (write) to the block size
// FIN   | one-cycle DONE/ERR strobe to the owner, then release
module sd_block_arbiter #(
   parameter int NREQ           = 2,
   parameter int BLOCK_BYTES    = 512,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input logic              CLK,
   input logic              RST,
   sd_block_arbiter_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(BLOCK_BYTES) + 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] RD_TARGET = CW'(BLOCK_BYTES);
   localparam logic [CW-1:0] WR_TARGET = CW'(BLOCK_BYTES / 4);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, XFER, FIN} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   ptr, owner, pick, idx;
   int              idx_i;
   logic            pick_vld, grant;
   logic            dir, to_flag;
   logic [CW-1:0]   cnt;
   logic [TW-1:0]   to_cnt;
   logic            byte_prev, wtake_prev, byte_ev, word_ev;
   logic [NREQ-1:0] owner_oh;
   logic            xfer_full, finish_ok, active, to_abort;

   assign byte_ev   = bus.SD_BYTE_READY & ~byte_prev;
   assign word_ev   = bus.SD_WTAKE & ~wtake_prev;
   assign owner_oh  = NREQ'(1) << owner;
   assign xfer_full = dir ? (cnt == WR_TARGET) : (cnt == RD_TARGET);
   assign finish_ok = (state == XFER) && xfer_full && bus.SD_READY;
   assign active    = (state == ISSUE) || (state == XFER);
   // a progress event in the same cycle as terminal count keeps the transfer alive
   assign to_abort  = active && (to_cnt == TO_LAST) && !byte_ev && !word_ev && !finish_ok;
   assign grant     = (state == IDLE) && bus.SD_READY && pick_vld;

   assign bus.GNT      = (state != IDLE) ? owner_oh : '0;
   assign bus.SD_READ  = (state == ISSUE) && !dir;
   assign bus.SD_WRITE = (state == ISSUE) && dir;
   assign bus.SD_WDATA = (state != IDLE) ? bus.REQ_WDATA[32*owner +: 32] : '0;
   assign bus.DONE     = (state == FIN) ? owner_oh : '0;
   assign bus.ERR      = (state == FIN && to_flag) ? owner_oh : '0;

   // round-robin search starting one past the last owner
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      idx_i    = 0;
      idx      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx_i = (int'(ptr) + k) % NREQ;
         idx   = PW'(idx_i);
         if (!pick_vld && bus.REQ[idx]) begin
            pick     = idx;
            pick_vld = 1'b1;
         end
      end
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant) state_nxt = ISSUE;
         ISSUE: begin
            if (to_abort)           state_nxt = FIN;
            else if (!bus.SD_READY) state_nxt = XFER;
         end
         XFER:    if (finish_ok || to_abort) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   // owner latch, counters, strobes and read data
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ptr         <= PW'(NREQ - 1);
         owner       <= '0;
         dir         <= 1'b0;
         to_flag     <= 1'b0;
         cnt         <= '0;
         to_cnt      <= '0;
         byte_prev   <= 1'b0;
         wtake_prev  <= 1'b0;
         bus.SD_ADDR <= '0;
         bus.RDATA   <= '0;
         bus.RVALID  <= '0;
         bus.WTAKE   <= '0;
      end else begin
         byte_prev  <= bus.SD_BYTE_READY;
         wtake_prev <= bus.SD_WTAKE;
         bus.RVALID <= '0;
         bus.WTAKE  <= '0;
         case (state)
            IDLE: begin
               if (grant) begin
                  owner       <= pick;
                  ptr         <= pick;
                  dir         <= bus.REQ_WRITE[pick];
                  bus.SD_ADDR <= bus.REQ_ADDR[32*pick +: 32];
                  to_cnt      <= '0;
                  to_flag     <= 1'b0;
               end
            end
            ISSUE, XFER: begin
               if (state == ISSUE) cnt <= '0;
               if (state == XFER && !xfer_full) begin
                  if (!dir && byte_ev) begin
                     bus.RDATA  <= bus.SD_RDATA;
                     bus.RVALID <= owner_oh;
                     cnt        <= cnt + 1'b1;
                  end
                  if (dir && word_ev) begin
                     bus.WTAKE <= owner_oh;
                     cnt       <= cnt + 1'b1;
                  end
               end
               if (to_abort)                 to_flag <= 1'b1;
               else if (byte_ev || word_ev)  to_cnt  <= '0;
               else if (to_cnt != TO_LAST)   to_cnt  <= to_cnt + 1'b1;
            end
            FIN:     to_flag <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sd_block_arbiter.sv
// Directed bench for sd_block_arbiter: table of block transfers plus
// contention and mid-transfer reset sequences.
module tb_sd_block_arbiter;
   localparam int NREQ = 2;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   sd_block_arbiter_if #(.NREQ(NREQ)) bus ();

   sd_block_arbiter #(.NREQ(NREQ), .BLOCK_BYTES(512), .TIMEOUT_CYCLES(100)) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   typedef struct {
      logic [1:0] req;
      logic [1:0] wr;
      int         n_ev;
      bit         stall;
      int         exp_owner;
      int         exp_strobes;
      bit         exp_err;
   } vec_t;

   vec_t vecs[5];

   int n_vec = 0;
   int n_bad = 0;
   int cyc_n = 0;
   int rv_cnt, wt_cnt, rv_bad, wt_bad, gnt_bad, done_cnt, done_cyc, last_ev_cyc, cur_owner;
   logic [1:0] done_mask, err_val, prev_gnt;

   function automatic logic [31:0] wword(input int o, input int k);
      return 32'hA000_0000 | (32'(o) << 24) | 32'(k & 16'hFFFF);
   endfunction

   function automatic logic [31:0] exp_addr(input int o);
      return (o == 1) ? 32'h2000_0040 : 32'h0000_0010;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   // one clock, then sample outputs and update the requester/controller model
   task automatic cyc();
      @(posedge CLK);
      #1;
      cyc_n++;
      if ($countones(bus.GNT) > 1) gnt_bad++;
      if (prev_gnt != 2'b00 && bus.GNT != 2'b00 && bus.GNT != prev_gnt) gnt_bad++;
      prev_gnt = bus.GNT;
      if (bus.RVALID != 2'b00) begin
         if (bus.RVALID != 2'(1 << cur_owner) || bus.RDATA != 8'(rv_cnt)) rv_bad++;
         rv_cnt++;
         last_ev_cyc = cyc_n;
      end
      if (bus.WTAKE != 2'b00) begin
         if (bus.WTAKE != 2'(1 << cur_owner) || bus.SD_WDATA != wword(cur_owner, wt_cnt)) wt_bad++;
         wt_cnt++;
         bus.REQ_WDATA[32*cur_owner +: 32] = wword(cur_owner, wt_cnt);
         last_ev_cyc = cyc_n;
      end
      if (bus.DONE != 2'b00) begin
         done_cnt++;
         done_mask = bus.DONE;
         err_val   = bus.ERR;
         done_cyc  = cyc_n;
      end
   endtask

   task automatic apply_reset();
      RST = 1'b0;
      bus.REQ = '0;
      bus.REQ_WRITE = '0;
      bus.SD_READY = 1'b0;
      bus.SD_BYTE_READY = 1'b0;
      bus.SD_WTAKE = 1'b0;
      bus.SD_RDATA = '0;
      repeat (3) cyc();
      prev_gnt = '0;
      RST = 1'b1;
   endtask

   task automatic do_xfer(input logic [1:0] req, input logic [1:0] wr, input int n_ev,
                          input bit stall, input int exp_owner, input int exp_strobes,
                          input bit exp_err, input bit keep_req);
      logic [1:0] m;
      bit got, dir;
      int done0;
      m = 2'(1 << exp_owner);
      dir = wr[exp_owner];
      cur_owner = exp_owner;
      rv_cnt = 0; wt_cnt = 0; rv_bad = 0; wt_bad = 0;
      done0 = done_cnt;
      bus.REQ_WDATA = {wword(1, 0), wword(0, 0)};
      bus.REQ = req;
      bus.REQ_WRITE = wr;
      bus.SD_READY = 1'b1;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         cyc();
         if (bus.GNT != 2'b00) got = 1;
      end
      chk("grant", 64'(bus.GNT), 64'(m));
      if (!got) begin
         bus.REQ = '0;
         return;
      end
      chk("sd_addr", 64'(bus.SD_ADDR), 64'(exp_addr(exp_owner)));
      chk("cmd", 64'({bus.SD_WRITE, bus.SD_READ}), dir ? 64'd2 : 64'd1);
      if (dir) chk("sd_wdata_first", 64'(bus.SD_WDATA), 64'(wword(exp_owner, 0)));
      repeat (3) cyc();
      chk("cmd_hold", 64'({bus.SD_WRITE, bus.SD_READ}), dir ? 64'd2 : 64'd1);
      bus.SD_READY = 1'b0;
      cyc();
      chk("cmd_drop", 64'({bus.SD_WRITE, bus.SD_READ}), 64'd0);
      for (int i = 0; i < n_ev; i++) begin
         if (dir) bus.SD_WTAKE = 1'b1;
         else begin
            bus.SD_BYTE_READY = 1'b1;
            bus.SD_RDATA = 8'(i);
         end
         cyc();
         cyc();
         bus.SD_BYTE_READY = 1'b0;
         bus.SD_WTAKE = 1'b0;
         cyc();
         cyc();
      end
      if (!stall) bus.SD_READY = 1'b1;
      got = 0;
      for (int k = 0; k < 300 && !got; k++) begin
         cyc();
         if (done_cnt != done0) got = 1;
      end
      chk("done_seen", 64'(got), 64'd1);
      chk("done_mask", 64'(done_mask), 64'(m));
      chk("err", 64'(err_val), exp_err ? 64'(m) : 64'd0);
      chk("strobe_count", dir ? 64'(wt_cnt) : 64'(rv_cnt), 64'(exp_strobes));
      chk("strobe_data", 64'(rv_bad + wt_bad), 64'd0);
      if (stall) chk("timeout_latency", 64'(done_cyc - last_ev_cyc), 64'd100);
      if (!keep_req) bus.REQ = '0;
   endtask

   initial begin
      bit gnt_any;
      int done0;
      rv_cnt = 0; wt_cnt = 0; rv_bad = 0; wt_bad = 0; gnt_bad = 0;
      done_cnt = 0; done_cyc = 0; last_ev_cyc = 0; cur_owner = 0;
      done_mask = '0; err_val = '0; prev_gnt = '0;
      bus.REQ_ADDR  = {32'h2000_0040, 32'h0000_0010};
      bus.REQ_WDATA = '0;

      vecs[0] = '{req: 2'b01, wr: 2'b00, n_ev: 512, stall: 0, exp_owner: 0, exp_strobes: 512, exp_err: 0};
      vecs[1] = '{req: 2'b10, wr: 2'b10, n_ev: 128, stall: 0, exp_owner: 1, exp_strobes: 128, exp_err: 0};
      vecs[2] = '{req: 2'b01, wr: 2'b00, n_ev: 520, stall: 0, exp_owner: 0, exp_strobes: 512, exp_err: 0};
      vecs[3] = '{req: 2'b01, wr: 2'b00, n_ev: 10,  stall: 1, exp_owner: 0, exp_strobes: 10,  exp_err: 1};
      vecs[4] = '{req: 2'b10, wr: 2'b00, n_ev: 512, stall: 0, exp_owner: 1, exp_strobes: 512, exp_err: 0};

      apply_reset();
      chk("reset_outputs",
          64'({bus.GNT, bus.RVALID, bus.WTAKE, bus.DONE, bus.ERR, bus.SD_READ, bus.SD_WRITE}), 64'd0);
      chk("reset_addr_rdata", 64'({bus.SD_ADDR, bus.RDATA}), 64'd0);

      for (int v = 0; v < 5; v++) begin
         do_xfer(vecs[v].req, vecs[v].wr, vecs[v].n_ev, vecs[v].stall, vecs[v].exp_owner,
                 vecs[v].exp_strobes, vecs[v].exp_err, vecs[v].stall);
         if (vecs[v].stall) begin
            gnt_any = 0;
            repeat (20) begin
               cyc();
               if (bus.GNT != 2'b00) gnt_any = 1;
            end
            chk("no_grant_while_busy", 64'(gnt_any), 64'd0);
            bus.REQ = '0;
            bus.SD_READY = 1'b1;
            cyc();
         end
      end

      // both requesters held from reset: grants alternate 0,1,0,1 with a gap
      apply_reset();
      gnt_bad = 0;
      do_xfer(2'b11, 2'b11, 128, 0, 0, 128, 0, 1);
      do_xfer(2'b11, 2'b11, 128, 0, 1, 128, 0, 1);
      do_xfer(2'b11, 2'b11, 128, 0, 0, 128, 0, 1);
      do_xfer(2'b11, 2'b11, 128, 0, 1, 128, 0, 0);
      chk("grant_overlap_or_gap", 64'(gnt_bad), 64'd0);
      cyc();

      // reset in the middle of a read, then requester 1 alone
      bus.REQ = 2'b01;
      bus.REQ_WRITE = 2'b00;
      bus.SD_READY = 1'b1;
      cur_owner = 0;
      rv_cnt = 0;
      gnt_any = 0;
      for (int k = 0; k < 20 && !gnt_any; k++) begin
         cyc();
         if (bus.GNT != 2'b00) gnt_any = 1;
      end
      chk("mid_rst_grant", 64'(bus.GNT), 64'd1);
      bus.SD_READY = 1'b0;
      cyc();
      for (int i = 0; i < 6; i++) begin
         bus.SD_BYTE_READY = 1'b1;
         bus.SD_RDATA = 8'(i + 1);
         cyc();
         if (i < 5) begin
            cyc();
            bus.SD_BYTE_READY = 1'b0;
            cyc();
            cyc();
         end
      end
      done0 = done_cnt;
      #2;
      RST = 1'b0;
      #1;
      chk("async_rst_outputs",
          64'({bus.GNT, bus.RVALID, bus.WTAKE, bus.DONE, bus.ERR, bus.SD_READ, bus.SD_WRITE}), 64'd0);
      chk("async_rst_addr_rdata", 64'({bus.SD_ADDR, bus.RDATA}), 64'd0);
      bus.SD_BYTE_READY = 1'b0;
      bus.REQ = '0;
      repeat (3) cyc();
      chk("no_done_on_reset", 64'(done_cnt - done0), 64'd0);
      prev_gnt = '0;
      RST = 1'b1;
      cyc();
      do_xfer(2'b10, 2'b00, 512, 0, 1, 512, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
      $fatal(1, "time limit");
   end
endmodule
